// File: rtl/forward_action_arbiter_if.sv
// ----------------------------------------------------------------------------
// forward_action_arbiter_if
// Bundles the requester-side descriptor bus, the action-stage handshake and
// the status outputs of forward_action_arbiter.
//   master : the arbiter itself (consumes requests, drives the action stage)
//   slave  : the surrounding lookup engines / action stage / bench
// Signals (NUM_REQ requesters, requester n at slice n of each packed vector):
//   iv_req, iv_req_bufid[9n+8:9n], iv_req_type[3n+2:3n], iv_req_inport[4n+3:4n],
//   iv_req_outport[9n+8:9n], iv_req_hit[n]       requester descriptors
//   ov_req_ack                                    one-hot grant-complete pulse
//   ov_pkt_bufid/type/inport, ov_outport,
//   o_mac_entry_hit, o_action_req, i_action_ack   action-stage handshake
//   ov_grant_cnt, o_timeout                       status
// ----------------------------------------------------------------------------
interface forward_action_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   iv_req;
    logic [NUM_REQ*9-1:0] iv_req_bufid;
    logic [NUM_REQ*3-1:0] iv_req_type;
    logic [NUM_REQ*4-1:0] iv_req_inport;
    logic [NUM_REQ*9-1:0] iv_req_outport;
    logic [NUM_REQ-1:0]   iv_req_hit;
    logic [NUM_REQ-1:0]   ov_req_ack;
    logic [8:0]           ov_pkt_bufid;
    logic [2:0]           ov_pkt_type;
    logic [3:0]           ov_pkt_inport;
    logic [8:0]           ov_outport;
    logic                 o_mac_entry_hit;
    logic                 o_action_req;
    logic                 i_action_ack;
    logic [15:0]          ov_grant_cnt;
    logic                 o_timeout;

    modport master (
        input  iv_req, iv_req_bufid, iv_req_type, iv_req_inport, iv_req_outport,
               iv_req_hit, i_action_ack,
        output ov_req_ack, ov_pkt_bufid, ov_pkt_type, ov_pkt_inport, ov_outport,
               o_mac_entry_hit, o_action_req, ov_grant_cnt, o_timeout
    );

    modport slave (
        output iv_req, iv_req_bufid, iv_req_type, iv_req_inport, iv_req_outport,
               iv_req_hit, i_action_ack,
        input  ov_req_ack, ov_pkt_bufid, ov_pkt_type, ov_pkt_inport, ov_outport,
               o_mac_entry_hit, o_action_req, ov_grant_cnt, o_timeout
    );
endinterface

// File: rtl/forward_action_arbiter.sv
// ----------------------------------------------------------------------------
// forward_action_arbiter
// Round-robin arbiter sharing the standard-packet forwarding action stage
// between NUM_REQ lookup engines. A granted descriptor is registered and
// presented with o_action_req until i_action_ack; the requester then gets a
// one-cycle ov_req_ack pulse and the pointer moves past it.
// Ports:
//   i_clk  : clock
//   i_rst  : asynchronous, active-high reset
//   bus    : forward_action_arbiter_if.master (requests, action handshake,
//            grant counter, timeout pulse)
// Optional feature (macro FWD_ARB_TIMEOUT_EN): watchdog that abandons an
// issue after TIMEOUT_CYCLES cycles without i_action_ack, pulsing o_timeout
// and acking the requester without counting the grant. Without the macro
// o_timeout is tied low and the issue waits indefinitely.
// ----------------------------------------------------------------------------
module forward_action_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic                      i_clk,
    input logic                      i_rst,
    forward_action_arbiter_if.master bus
);
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
            $error("forward_action_arbiter: NUM_REQ must be 2..8");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("forward_action_arbiter: TIMEOUT_CYCLES must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE_S    = 2'd0,
        ISSUE_S   = 2'd1,
        RELEASE_S = 2'd2
    } state_t;

    state_t             state_q;
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [PTR_W-1:0]   gnt_q;
    logic [8:0]         bufid_q;
    logic [2:0]         type_q;
    logic [3:0]         inport_q;
    logic [8:0]         outport_q;
    logic               hit_q;
    logic               action_req_q;
    logic [NUM_REQ-1:0] req_ack_q;
    logic [15:0]        grant_cnt_q;

`ifdef FWD_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]    to_cnt_q;
    logic               timeout_q;
`endif

    logic               sel_valid_d;
    logic [PTR_W-1:0]   sel_d;
    logic [PTR_W-1:0]   scan_idx;
    int unsigned        sel_n;
    logic [8:0]         sel_bufid_d;
    logic [2:0]         sel_type_d;
    logic [3:0]         sel_inport_d;
    logic [8:0]         sel_outport_d;
    logic               sel_hit_d;
    logic [PTR_W-1:0]   nxt_ptr_d;

    // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        sel_valid_d = 1'b0;
        sel_d       = '0;
        scan_idx    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan_idx = PTR_W'((32'(rr_ptr_q) + i) % NUM_REQ);
            if (!sel_valid_d && bus.iv_req[scan_idx]) begin
                sel_valid_d = 1'b1;
                sel_d       = scan_idx;
            end
        end
    end

    always_comb begin
        sel_n         = 32'(sel_d);
        sel_bufid_d   = bus.iv_req_bufid[9*sel_n +: 9];
        sel_type_d    = bus.iv_req_type[3*sel_n +: 3];
        sel_inport_d  = bus.iv_req_inport[4*sel_n +: 4];
        sel_outport_d = bus.iv_req_outport[9*sel_n +: 9];
        sel_hit_d     = bus.iv_req_hit[sel_n];
    end

    assign nxt_ptr_d = (32'(gnt_q) == NUM_REQ - 1) ? '0 : gnt_q + 1'b1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE_S;
            rr_ptr_q     <= '0;
            gnt_q        <= '0;
            bufid_q      <= '0;
            type_q       <= '0;
            inport_q     <= '0;
            outport_q    <= '0;
            hit_q        <= 1'b0;
            action_req_q <= 1'b0;
            req_ack_q    <= '0;
            grant_cnt_q  <= '0;
`ifdef FWD_ARB_TIMEOUT_EN
            to_cnt_q     <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE_S: begin
                    req_ack_q <= '0;
                    if (sel_valid_d) begin
                        gnt_q        <= sel_d;
                        bufid_q      <= sel_bufid_d;
                        type_q       <= sel_type_d;
                        inport_q     <= sel_inport_d;
                        outport_q    <= sel_outport_d;
                        hit_q        <= sel_hit_d;
                        action_req_q <= 1'b1;
                        state_q      <= ISSUE_S;
`ifdef FWD_ARB_TIMEOUT_EN
                        to_cnt_q     <= '0;
`endif
                    end
                end

                // Inputs are not looked at here: the descriptor is latched.
                ISSUE_S: begin
                    if (bus.i_action_ack) begin
                        bufid_q      <= '0;
                        type_q       <= '0;
                        inport_q     <= '0;
                        outport_q    <= '0;
                        hit_q        <= 1'b0;
                        action_req_q <= 1'b0;
                        req_ack_q    <= NUM_REQ'(1) << gnt_q;
                        grant_cnt_q  <= grant_cnt_q + 16'd1;
                        rr_ptr_q     <= nxt_ptr_d;
                        state_q      <= RELEASE_S;
                    end
`ifdef FWD_ARB_TIMEOUT_EN
                    // Abandoned issue: requester still acked, grant not counted.
                    else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        bufid_q      <= '0;
                        type_q       <= '0;
                        inport_q     <= '0;
                        outport_q    <= '0;
                        hit_q        <= 1'b0;
                        action_req_q <= 1'b0;
                        req_ack_q    <= NUM_REQ'(1) << gnt_q;
                        timeout_q    <= 1'b1;
                        rr_ptr_q     <= nxt_ptr_d;
                        state_q      <= RELEASE_S;
                    end else begin
                        to_cnt_q     <= to_cnt_q + 1'b1;
                    end
`endif
                end

                // Dead cycle so the acked requester can drop iv_req before
                // the next arbitration samples it.
                RELEASE_S: begin
                    req_ack_q <= '0;
`ifdef FWD_ARB_TIMEOUT_EN
                    timeout_q <= 1'b0;
`endif
                    state_q   <= IDLE_S;
                end

                default: begin
                    bufid_q      <= '0;
                    type_q       <= '0;
                    inport_q     <= '0;
                    outport_q    <= '0;
                    hit_q        <= 1'b0;
                    action_req_q <= 1'b0;
                    req_ack_q    <= '0;
`ifdef FWD_ARB_TIMEOUT_EN
                    timeout_q    <= 1'b0;
`endif
                    state_q      <= IDLE_S;
                end
            endcase
        end
    end

    assign bus.ov_req_ack      = req_ack_q;
    assign bus.ov_pkt_bufid    = bufid_q;
    assign bus.ov_pkt_type     = type_q;
    assign bus.ov_pkt_inport   = inport_q;
    assign bus.ov_outport      = outport_q;
    assign bus.o_mac_entry_hit = hit_q;
    assign bus.o_action_req    = action_req_q;
    assign bus.ov_grant_cnt    = grant_cnt_q;
`ifdef FWD_ARB_TIMEOUT_EN
    assign bus.o_timeout       = timeout_q;
`else
    assign bus.o_timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_forward_action_arbiter.sv
// ----------------------------------------------------------------------------
// tb_forward_action_arbiter
// Self-checking bench for forward_action_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=8).
// Expected grants are queued when requests are raised and popped as each
// grant completes on the action-stage handshake.
// ----------------------------------------------------------------------------
module tb_forward_action_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #4 clk = ~clk;

    forward_action_arbiter_if #(.NUM_REQ(N)) bus ();

    forward_action_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        int         idx;
        logic [8:0] bufid;
        logic [2:0] typ;
        logic [3:0] inport;
        logic [8:0] outport;
        logic       hit;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int checks = 0;
    int passes = 0;

    logic [8:0] d_bufid[N];
    logic [2:0] d_type[N];
    logic [3:0] d_inport[N];
    logic [8:0] d_outport[N];
    logic       d_hit[N];

    // Observations from the most recent serve() call.
    bit         obs_got;
    int         obs_lat;
    int         obs_high;
    bit         obs_stable;
    logic [25:0] obs_desc;
    logic [N-1:0] obs_ack;
    logic       obs_after_req;
    bit         obs_after_zero;
    logic [N-1:0] exp_ack;

    function automatic logic [25:0] cur_desc();
        return {bus.ov_pkt_bufid, bus.ov_pkt_type, bus.ov_pkt_inport,
                bus.ov_outport, bus.o_mac_entry_hit};
    endfunction

    function automatic logic [25:0] exp_desc(input exp_t x);
        return {x.bufid, x.typ, x.inport, x.outport, x.hit};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_desc(input int n, input logic [8:0] b, input logic [2:0] t,
                            input logic [3:0] ip, input logic [8:0] op, input logic h);
        d_bufid[n] = b; d_type[n] = t; d_inport[n] = ip; d_outport[n] = op; d_hit[n] = h;
        bus.iv_req_bufid[9*n +: 9]   = b;
        bus.iv_req_type[3*n +: 3]    = t;
        bus.iv_req_inport[4*n +: 4]  = ip;
        bus.iv_req_outport[9*n +: 9] = op;
        bus.iv_req_hit[n]            = h;
    endtask

    task automatic restore_inputs();
        for (int n = 0; n < int'(N); n++)
            set_desc(n, d_bufid[n], d_type[n], d_inport[n], d_outport[n], d_hit[n]);
    endtask

    task automatic push_exp(input int n);
        exp_t x;
        x.idx = n; x.bufid = d_bufid[n]; x.typ = d_type[n];
        x.inport = d_inport[n]; x.outport = d_outport[n]; x.hit = d_hit[n];
        sb.push_back(x);
    endtask

    // Acts as the action stage for one grant: waits (bounded) for o_action_req,
    // acks ack_delay cycles later, and records what the DUT showed.
    task automatic serve(input int ack_delay, input bit drop_on_ack, input bit perturb);
        obs_got = 0; obs_lat = 0; obs_high = 0; obs_stable = 1;
        obs_ack = '0; obs_after_req = 1'bx; obs_after_zero = 0;
        for (int c = 0; c < 64; c++) begin
            if (bus.o_action_req === 1'b1) begin
                obs_got = 1;
                break;
            end
            tick();
            obs_lat++;
        end
        if (!obs_got) return;
        obs_desc = cur_desc();
        obs_high = 1;
        if (perturb) begin
            bus.iv_req         = '0;
            bus.iv_req_bufid   = ~bus.iv_req_bufid;
            bus.iv_req_type    = ~bus.iv_req_type;
            bus.iv_req_inport  = ~bus.iv_req_inport;
            bus.iv_req_outport = ~bus.iv_req_outport;
            bus.iv_req_hit     = ~bus.iv_req_hit;
        end
        repeat (ack_delay) begin
            tick();
            if (bus.o_action_req === 1'b1) obs_high++;
            if (cur_desc() !== obs_desc) obs_stable = 0;
        end
        bus.i_action_ack = 1'b1;
        tick();
        bus.i_action_ack = 1'b0;
        obs_ack        = bus.ov_req_ack;
        obs_after_req  = bus.o_action_req;
        obs_after_zero = (cur_desc() === 26'd0);
        if (drop_on_ack) bus.iv_req = bus.iv_req & ~bus.ov_req_ack;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.iv_req = '0; bus.i_action_ack = 1'b0;
        for (int n = 0; n < int'(N); n++) set_desc(n, '0, '0, '0, '0, 1'b0);
        repeat (3) tick();
        checks++; if (bus.o_action_req !== 1'b0) $display("FAIL reset_req: got %b expected 0", bus.o_action_req); else passes++;
        checks++; if (bus.ov_req_ack !== 4'b0000) $display("FAIL reset_ack: got %b expected 0000", bus.ov_req_ack); else passes++;
        checks++; if (bus.ov_grant_cnt !== 16'd0) $display("FAIL reset_cnt: got %h expected 0000", bus.ov_grant_cnt); else passes++;
        checks++; if (cur_desc() !== 26'd0) $display("FAIL reset_desc: got %h expected 0", cur_desc()); else passes++;
        checks++; if (bus.o_timeout !== 1'b0) $display("FAIL reset_timeout: got %b expected 0", bus.o_timeout); else passes++;
        rst = 1'b0;
        repeat (2) tick();
        checks++; if (bus.o_action_req !== 1'b0) $display("FAIL idle_no_req: got %b expected 0", bus.o_action_req); else passes++;
    endtask

    task automatic test_single();
        set_desc(2, 9'h05A, 3'd5, 4'd2, 9'h003, 1'b1);
        push_exp(2);
        bus.iv_req = 4'b0100;
        serve(2, 1, 0);
        e = sb.pop_front();
        checks++; if (!obs_got) $display("FAIL single_got: got no o_action_req expected one"); else passes++;
        checks++; if (obs_lat !== 1) $display("FAIL single_latency: got %0d expected 1", obs_lat); else passes++;
        checks++; if (obs_desc !== exp_desc(e)) $display("FAIL single_desc: got %h expected %h", obs_desc, exp_desc(e)); else passes++;
        checks++; if (obs_high !== 3) $display("FAIL single_req_len: got %0d expected 3", obs_high); else passes++;
        checks++; if (!obs_stable) $display("FAIL single_stable: got changing descriptor expected stable"); else passes++;
        checks++; if (obs_ack !== 4'b0100) $display("FAIL single_ack: got %b expected 0100", obs_ack); else passes++;
        checks++; if (obs_after_req !== 1'b0) $display("FAIL single_req_drop: got %b expected 0", obs_after_req); else passes++;
        checks++; if (!obs_after_zero) $display("FAIL single_desc_clear: got %h expected 0", cur_desc()); else passes++;
        checks++; if (bus.ov_grant_cnt !== 16'd1) $display("FAIL single_cnt: got %h expected 0001", bus.ov_grant_cnt); else passes++;
        tick();
        checks++; if (bus.ov_req_ack !== 4'b0000) $display("FAIL single_ack_len: got %b expected 0000", bus.ov_req_ack); else passes++;
    endtask

    task automatic test_rotation();
        do_reset();
        set_desc(0, 9'h101, 3'd1, 4'd0, 9'h000, 1'b0);
        set_desc(1, 9'h0F2, 3'd2, 4'd1, 9'h1FF, 1'b1);
        set_desc(2, 9'h033, 3'd3, 4'd2, 9'h100, 1'b0);
        set_desc(3, 9'h1C4, 3'd7, 4'd3, 9'h081, 1'b1);
        push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
        bus.iv_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            serve(1, 0, 0);
            if (k == 4) bus.iv_req = '0;
            e = sb.pop_front();
            exp_ack = 4'b0001 << e.idx;
            checks++; if (obs_ack !== exp_ack) $display("FAIL rot_ack%0d: got %b expected %b", k, obs_ack, exp_ack); else passes++;
            checks++; if (obs_desc !== exp_desc(e)) $display("FAIL rot_desc%0d: got %h expected %h", k, obs_desc, exp_desc(e)); else passes++;
        end
        checks++; if (bus.ov_grant_cnt !== 16'd5) $display("FAIL rot_cnt: got %h expected 0005", bus.ov_grant_cnt); else passes++;
        // Stray ack while idle must not complete anything.
        repeat (3) tick();
        bus.i_action_ack = 1'b1;
        tick();
        bus.i_action_ack = 1'b0;
        tick();
        checks++; if (bus.ov_req_ack !== 4'b0000) $display("FAIL stray_ack: got %b expected 0000", bus.ov_req_ack); else passes++;
        checks++; if (bus.ov_grant_cnt !== 16'd5) $display("FAIL stray_cnt: got %h expected 0005", bus.ov_grant_cnt); else passes++;
    endtask

    task automatic test_drop_during_issue();
        set_desc(1, 9'h155, 3'd6, 4'd9, 9'h0AA, 1'b1);
        push_exp(1);
        bus.iv_req = 4'b0010;
        serve(3, 1, 1);
        restore_inputs();
        e = sb.pop_front();
        checks++; if (obs_desc !== exp_desc(e)) $display("FAIL drop_desc: got %h expected %h", obs_desc, exp_desc(e)); else passes++;
        checks++; if (!obs_stable) $display("FAIL drop_stable: got changing descriptor expected stable"); else passes++;
        checks++; if (obs_ack !== 4'b0010) $display("FAIL drop_ack: got %b expected 0010", obs_ack); else passes++;
        checks++; if (bus.ov_grant_cnt !== 16'd6) $display("FAIL drop_cnt: got %h expected 0006", bus.ov_grant_cnt); else passes++;
    endtask

    task automatic test_cnt_wrap();
        // Preload stands in for 65534 earlier grants.
        force dut.grant_cnt_q = 16'hFFFE;
        #1;
        release dut.grant_cnt_q;
        set_desc(3, 9'h000, 3'd0, 4'd15, 9'h000, 1'b0);
        push_exp(3); push_exp(3);
        bus.iv_req = 4'b1000;
        serve(0, 0, 0);
        e = sb.pop_front();
        checks++; if (obs_ack !== 4'b1000) $display("FAIL wrap_ack0: got %b expected 1000", obs_ack); else passes++;
        checks++; if (obs_desc !== exp_desc(e)) $display("FAIL wrap_desc0: got %h expected %h", obs_desc, exp_desc(e)); else passes++;
        checks++; if (bus.ov_grant_cnt !== 16'hFFFF) $display("FAIL wrap_cnt_ffff: got %h expected ffff", bus.ov_grant_cnt); else passes++;
        serve(0, 1, 0);
        e = sb.pop_front();
        checks++; if (obs_ack !== 4'b1000) $display("FAIL wrap_ack1: got %b expected 1000", obs_ack); else passes++;
        checks++; if (bus.ov_grant_cnt !== 16'h0000) $display("FAIL wrap_cnt_0: got %h expected 0000", bus.ov_grant_cnt); else passes++;
    endtask

    task automatic test_reset_mid();
        bit seen;
        push_exp(2);
        bus.iv_req = 4'b0100;
        serve(0, 1, 0);
        e = sb.pop_front();
        checks++; if (obs_ack !== 4'b0100) $display("FAIL rmid_pre_ack: got %b expected 0100", obs_ack); else passes++;
        bus.iv_req = 4'b1010;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.o_action_req === 1'b1) begin
                seen = 1;
                break;
            end
            tick();
        end
        checks++; if (!seen || bus.ov_pkt_bufid !== d_bufid[3]) $display("FAIL rmid_pre_grant: got req=%b bufid=%h expected req=1 bufid=%h", seen, bus.ov_pkt_bufid, d_bufid[3]); else passes++;
        rst = 1'b1;
        #1;
        checks++; if (bus.o_action_req !== 1'b0) $display("FAIL rmid_req: got %b expected 0", bus.o_action_req); else passes++;
        checks++; if (bus.ov_req_ack !== 4'b0000) $display("FAIL rmid_ack: got %b expected 0000", bus.ov_req_ack); else passes++;
        checks++; if (bus.ov_grant_cnt !== 16'd0) $display("FAIL rmid_cnt: got %h expected 0000", bus.ov_grant_cnt); else passes++;
        checks++; if (cur_desc() !== 26'd0) $display("FAIL rmid_desc: got %h expected 0", cur_desc()); else passes++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_exp(1); push_exp(3);
        for (int k = 0; k < 2; k++) begin
            serve(1, 1, 0);
            e = sb.pop_front();
            exp_ack = 4'b0001 << e.idx;
            checks++; if (obs_ack !== exp_ack) $display("FAIL rmid_ack%0d: got %b expected %b", k, obs_ack, exp_ack); else passes++;
            checks++; if (obs_desc !== exp_desc(e)) $display("FAIL rmid_desc%0d: got %h expected %h", k, obs_desc, exp_desc(e)); else passes++;
        end
        checks++; if (bus.ov_grant_cnt !== 16'd2) $display("FAIL rmid_cnt_after: got %h expected 0002", bus.ov_grant_cnt); else passes++;
    endtask

`ifdef FWD_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit seen;
        int high;
        logic [25:0] d;
        push_exp(0); push_exp(2);
        bus.iv_req = 4'b0101;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.o_action_req === 1'b1) begin
                seen = 1;
                break;
            end
            tick();
        end
        d = cur_desc();
        high = seen ? 1 : 0;
        for (int c = 0; c < 40 && seen; c++) begin
            tick();
            if (bus.o_action_req === 1'b1) high++;
            else break;
        end
        e = sb.pop_front();
        checks++; if (d !== exp_desc(e)) $display("FAIL to_desc: got %h expected %h", d, exp_desc(e)); else passes++;
        checks++; if (high !== int'(TO)) $display("FAIL to_req_len: got %0d expected %0d", high, TO); else passes++;
        checks++; if (bus.o_timeout !== 1'b1) $display("FAIL to_pulse: got %b expected 1", bus.o_timeout); else passes++;
        checks++; if (bus.ov_req_ack !== 4'b0001) $display("FAIL to_ack: got %b expected 0001", bus.ov_req_ack); else passes++;
        checks++; if (bus.ov_grant_cnt !== 16'd2) $display("FAIL to_cnt: got %h expected 0002", bus.ov_grant_cnt); else passes++;
        bus.iv_req[0] = 1'b0;
        tick();
        checks++; if (bus.o_timeout !== 1'b0) $display("FAIL to_pulse_len: got %b expected 0", bus.o_timeout); else passes++;
        serve(1, 1, 0);
        e = sb.pop_front();
        checks++; if (obs_ack !== 4'b0100) $display("FAIL to_next_ack: got %b expected 0100", obs_ack); else passes++;
        checks++; if (obs_desc !== exp_desc(e)) $display("FAIL to_next_desc: got %h expected %h", obs_desc, exp_desc(e)); else passes++;
        checks++; if (bus.ov_grant_cnt !== 16'd3) $display("FAIL to_next_cnt: got %h expected 0003", bus.ov_grant_cnt); else passes++;
    endtask
`else
    task automatic test_no_timeout();
        bit seen;
        bit bad;
        push_exp(0);
        bus.iv_req = 4'b0001;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.o_action_req === 1'b1) begin
                seen = 1;
                break;
            end
            tick();
        end
        bad = !seen;
        repeat (3 * TO) begin
            tick();
            if (bus.o_action_req !== 1'b1 || bus.o_timeout !== 1'b0) bad = 1;
        end
        checks++; if (bad) $display("FAIL no_timeout_hold: got req=%b timeout=%b expected req=1 timeout=0", bus.o_action_req, bus.o_timeout); else passes++;
        serve(0, 1, 0);
        e = sb.pop_front();
        checks++; if (obs_ack !== 4'b0001) $display("FAIL no_timeout_ack: got %b expected 0001", obs_ack); else passes++;
        checks++; if (obs_desc !== exp_desc(e)) $display("FAIL no_timeout_desc: got %h expected %h", obs_desc, exp_desc(e)); else passes++;
        checks++; if (bus.ov_grant_cnt !== 16'd3) $display("FAIL no_timeout_cnt: got %h expected 0003", bus.ov_grant_cnt); else passes++;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_drop_during_issue();
        test_cnt_wrap();
        test_reset_mid();
`ifdef FWD_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
